// File: rtl/pdetect_stream_monitor.sv
// Pass-through byte stream monitor that flags when the newest accepted bytes equal PATTERN.
// Optional 16-bit saturating match counter when PDETECT_MATCH_COUNT_EN is defined.
module pdetect_stream_monitor #(
    parameter logic [63:0] PATTERN       = 64'h0A0B0C0D,
    parameter int          PATTERN_BYTES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_m_data,
    input  logic        i_m_valid,
    output logic        o_m_ready,
    output logic [7:0]  o_s_data,
    output logic        o_s_valid,
    input  logic        i_s_ready,
    output logic        o_detected
`ifdef PDETECT_MATCH_COUNT_EN
    ,
    output logic [15:0] o_match_count
`endif
);

    localparam int             W    = 8 * PATTERN_BYTES;
    localparam int             CW   = $clog2(PATTERN_BYTES + 1);
    localparam logic [W-1:0]   PAT  = PATTERN[W-1:0];
    localparam logic [CW-1:0]  FULL = CW'(PATTERN_BYTES);

    logic [W-1:0]  hist;
    logic [W-1:0]  hist_next;
    logic [CW-1:0] fill;
    logic [CW-1:0] fill_next;
    logic          accept;
    logic          match;

    assign o_s_data  = i_m_data;
    assign o_s_valid = i_m_valid;
    assign o_m_ready = i_s_ready;

    assign accept = i_m_valid & i_s_ready;

    always_comb begin
        hist_next = (hist << 8) | W'(i_m_data);
        fill_next = (fill == FULL) ? fill : fill + CW'(1);
        match     = (fill_next == FULL) && (hist_next == PAT);
    end

    // Fill gating keeps an all-zero pattern from matching the reset history.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hist       <= '0;
            fill       <= '0;
            o_detected <= 1'b0;
        end else if (accept) begin
            hist       <= hist_next;
            fill       <= fill_next;
            o_detected <= match;
        end
    end

`ifdef PDETECT_MATCH_COUNT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_match_count <= '0;
        end else if (accept && match && (o_match_count != 16'hFFFF)) begin
            o_match_count <= o_match_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pdetect_stream_monitor.sv
// Scoreboard bench for pdetect_stream_monitor: default pattern instance plus an
// all-zero pattern instance sharing the same stimulus.
module tb_pdetect_stream_monitor;

    localparam int          N     = 4;
    localparam logic [63:0] PAT_A = 64'h0A0B0C0D;
    localparam logic [63:0] PAT_Z = 64'h0;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_m_data = 8'h00;
    logic       i_m_valid = 1'b0;
    logic       i_s_ready = 1'b0;

    logic       o_m_ready, o_s_valid, o_detected;
    logic [7:0] o_s_data;
    logic       z_m_ready, z_s_valid, z_detected;
    logic [7:0] z_s_data;
`ifdef PDETECT_MATCH_COUNT_EN
    logic [15:0] o_match_count, z_match_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] acc_q[$];
    logic       exp_q[$];
    logic       expz_q[$];
    logic       exp_det = 1'b0;
    logic       exp_detz = 1'b0;
    int         exp_cnt = 0;
    int         expz_cnt = 0;

    pdetect_stream_monitor #(
        .PATTERN(PAT_A), .PATTERN_BYTES(N)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m_data(i_m_data), .i_m_valid(i_m_valid), .o_m_ready(o_m_ready),
        .o_s_data(o_s_data), .o_s_valid(o_s_valid), .i_s_ready(i_s_ready),
        .o_detected(o_detected)
`ifdef PDETECT_MATCH_COUNT_EN
        , .o_match_count(o_match_count)
`endif
    );

    pdetect_stream_monitor #(
        .PATTERN(PAT_Z), .PATTERN_BYTES(N)
    ) u_zero (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m_data(i_m_data), .i_m_valid(i_m_valid), .o_m_ready(z_m_ready),
        .o_s_data(z_s_data), .o_s_valid(z_s_valid), .i_s_ready(i_s_ready),
        .o_detected(z_detected)
`ifdef PDETECT_MATCH_COUNT_EN
        , .o_match_count(z_match_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference: compare the newest N accepted bytes against the pattern, oldest first.
    function automatic logic model_match(input logic [63:0] pat);
        int sz;
        logic [7:0] want;
        sz = acc_q.size();
        if (sz < N) return 1'b0;
        for (int i = 0; i < N; i++) begin
            want = pat[8*(N-1-i) +: 8];
            if (acc_q[sz-N+i] != want) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        acc_q.delete();
        exp_det  = 1'b0;
        exp_detz = 1'b0;
        exp_cnt  = 0;
        expz_cnt = 0;
    endfunction

    task automatic beat(input logic [7:0] d, input string tag);
        logic e, ez;
        @(negedge i_clk);
        i_m_data  = d;
        i_m_valid = 1'b1;
        i_s_ready = 1'b1;
        acc_q.push_back(d);
        if (acc_q.size() > 8) void'(acc_q.pop_front());
        exp_det  = model_match(PAT_A);
        exp_detz = model_match(PAT_Z);
        if (exp_det && exp_cnt < 65535) exp_cnt++;
        if (exp_detz && expz_cnt < 65535) expz_cnt++;
        exp_q.push_back(exp_det);
        expz_q.push_back(exp_detz);
        #1;
        n_cmp++;
        if (o_s_data !== d || o_s_valid !== 1'b1 || o_m_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s datapath: data=%h valid=%b ready=%b, required %h 1 1",
                     tag, o_s_data, o_s_valid, o_m_ready, d);
        end
        @(posedge i_clk);
        #1;
        i_m_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0 || expz_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e  = exp_q.pop_front();
            ez = expz_q.pop_front();
            if (o_detected !== e || z_detected !== ez) begin
                n_bad++;
                $display("FAIL %s detected after %h: got %b/%b, required %b/%b",
                         tag, d, o_detected, z_detected, e, ez);
            end
        end
`ifdef PDETECT_MATCH_COUNT_EN
        n_cmp++;
        if (o_match_count !== 16'(exp_cnt) || z_match_count !== 16'(expz_cnt)) begin
            n_bad++;
            $display("FAIL %s match_count: got %0d/%0d, required %0d/%0d",
                     tag, o_match_count, z_match_count, exp_cnt, expz_cnt);
        end
`endif
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge i_clk);
            i_m_valid = 1'b0;
            i_s_ready = 1'b1;
            i_m_data  = 8'hA5;
            #1;
            n_cmp++;
            if (o_s_valid !== 1'b0 || o_s_data !== 8'hA5) begin
                n_bad++;
                $display("FAIL %s idle datapath: valid=%b data=%h, required 0 a5",
                         tag, o_s_valid, o_s_data);
            end
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_detected !== exp_det || z_detected !== exp_detz) begin
                n_bad++;
                $display("FAIL %s idle hold: got %b/%b, required %b/%b",
                         tag, o_detected, z_detected, exp_det, exp_detz);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst     = 1'b0;
        i_m_valid = 1'b0;
        i_s_ready = 1'b0;
        model_reset();
        repeat (10) @(negedge i_clk);
        n_cmp++;
        if (o_detected !== 1'b0 || z_detected !== 1'b0) begin
            n_bad++;
            $display("FAIL reset detected: got %b/%b, required 0/0", o_detected, z_detected);
        end
`ifdef PDETECT_MATCH_COUNT_EN
        n_cmp++;
        if (o_match_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset match_count: got %0d, required 0", o_match_count);
        end
`endif
        i_rst = 1'b1;
        idle(10, "post_reset");
    endtask

    task automatic test_basic_match();
        beat(8'h0A, "basic");
        beat(8'h0B, "basic");
        beat(8'h0C, "basic");
        beat(8'h0D, "basic");
        n_cmp++;
        if (o_detected !== 1'b1) begin
            n_bad++;
            $display("FAIL basic flag: got %b, required 1", o_detected);
        end
        idle(2, "basic_hold");
    endtask

    task automatic test_non_match();
        repeat (4) beat(8'h0F, "nonmatch");
        n_cmp++;
        if (o_detected !== 1'b0) begin
            n_bad++;
            $display("FAIL nonmatch flag: got %b, required 0", o_detected);
        end
    endtask

    task automatic test_redetect();
        beat(8'h0A, "redetect");
        beat(8'h0B, "redetect");
        beat(8'h0C, "redetect");
        beat(8'h0D, "redetect");
`ifdef PDETECT_MATCH_COUNT_EN
        n_cmp++;
        if (o_match_count !== 16'd2) begin
            n_bad++;
            $display("FAIL redetect count: got %0d, required 2", o_match_count);
        end
`endif
    endtask

    task automatic test_stall();
        beat(8'h0A, "stall");
        beat(8'h0B, "stall");
        repeat (3) begin
            @(negedge i_clk);
            i_m_data  = 8'h0C;
            i_m_valid = 1'b1;
            i_s_ready = 1'b0;
            #1;
            n_cmp++;
            if (o_m_ready !== 1'b0 || o_s_valid !== 1'b1 || o_s_data !== 8'h0C) begin
                n_bad++;
                $display("FAIL stall datapath: ready=%b valid=%b data=%h, required 0 1 0c",
                         o_m_ready, o_s_valid, o_s_data);
            end
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_detected !== exp_det || z_detected !== exp_detz) begin
                n_bad++;
                $display("FAIL stall hold: got %b/%b, required %b/%b",
                         o_detected, z_detected, exp_det, exp_detz);
            end
        end
        beat(8'h0C, "stall_release");
        beat(8'h0D, "stall_release");
        n_cmp++;
        if (o_detected !== 1'b1) begin
            n_bad++;
            $display("FAIL stall final flag: got %b, required 1", o_detected);
        end
    endtask

    task automatic test_zero_pattern();
        test_reset();
        for (int i = 0; i < 5; i++) beat(8'h00, "zero");
        n_cmp++;
        if (z_detected !== 1'b1) begin
            n_bad++;
            $display("FAIL zero overlap flag: got %b, required 1", z_detected);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (o_detected !== 1'b0 || z_detected !== 1'b0) begin
            n_bad++;
            $display("FAIL %s async: got %b/%b, required 0/0", tag, o_detected, z_detected);
        end
        #1;
        i_rst = 1'b1;
    endtask

    task automatic test_async_reset();
        test_reset();
        beat(8'h0A, "async");
        beat(8'h0B, "async");
        beat(8'h0C, "async");
        beat(8'h0D, "async");
        pulse_reset("async_after_match");
        beat(8'h0A, "async_mid");
        beat(8'h0B, "async_mid");
        pulse_reset("async_mid");
        beat(8'h0C, "async_mid");
        beat(8'h0D, "async_mid");
        n_cmp++;
        if (o_detected !== 1'b0) begin
            n_bad++;
            $display("FAIL async partial discard: got %b, required 0", o_detected);
        end
        beat(8'h0A, "async_again");
        beat(8'h0B, "async_again");
        beat(8'h0C, "async_again");
        beat(8'h0D, "async_again");
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_non_match();
        test_redetect();
        test_stall();
        test_zero_pattern();
        test_async_reset();
        idle(2, "tail");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
